// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, captures ROM output into the IR with stall/redirect handling.
// Optional feature macro: JMP_FOLD_EN (resolve JMP opcodes locally in fetch).
`default_nettype none

module fetch_stage #(
  parameter int                PC_W     = 8,
  parameter int                OP_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pc,
  input  logic [OP_W-1:0]   op,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [OP_W-1:0]   ir,
  output logic [PC_W-1:0]   ir_pc,
  output logic              ir_valid,
  output logic [15:0]       fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [OP_W-1:0]   ir_q, ir_d;
  logic [PC_W-1:0]   ir_pc_q, ir_pc_d;
  logic              valid_q, valid_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              fold;

`ifdef JMP_FOLD_EN
  localparam logic [3:0] JMP_OPC = 4'hB;
  assign fold = (op[OP_W-1 -: 4] == JMP_OPC);
`else
  assign fold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      default: begin
        // FLUSH and HOLD-release both behave exactly like RUN.
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = S_FLUSH;
        end else if (stall) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_RUN;
          if (fold) begin
            pc_d    = op[PC_W+3:4];
            valid_d = 1'b0;
          end else begin
            ir_d    = op;
            ir_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
            cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          end
        end
      end
    endcase
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = valid_q;
  assign fetch_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/redirect traffic.
`default_nettype none

module tb_fetch_stage;

  localparam logic [3:0] JMP = 4'hB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pc;
  logic [15:0] op;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic [15:0] fetch_cnt;

  logic [15:0] rom [256];
  assign op = rom[pc];

  fetch_stage #(.PC_W(8), .OP_W(16), .RESET_PC(8'd0)) dut (
    .clk(clk), .rst(rst), .pc(pc), .op(op), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .ir(ir),
    .ir_pc(ir_pc), .ir_valid(ir_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural state only.
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_irpc;
  logic        m_v;
  int          m_cnt;
  bit          m_boot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'd0; m_ir = 16'd0; m_irpc = 8'd0; m_v = 1'b0; m_cnt = 0; m_boot = 1'b1;
  endtask

  task automatic model_edge();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (redirect) begin
      m_pc = redirect_pc;
      m_v  = 1'b0;
    end else if (!stall) begin
`ifdef JMP_FOLD_EN
      if (rom[m_pc][15:12] == JMP) begin
        m_pc = rom[m_pc][11:4];
        m_v  = 1'b0;
      end else
`endif
      begin
        m_ir   = rom[m_pc];
        m_irpc = m_pc;
        m_v    = 1'b1;
        if (m_cnt < 65535) m_cnt++;
        m_pc   = m_pc + 8'd1;
      end
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".pc"},    {24'd0, pc},       {24'd0, m_pc});
    chk({tag, ".ir"},    {16'd0, ir},       {16'd0, m_ir});
    chk({tag, ".ir_pc"}, {24'd0, ir_pc},    {24'd0, m_irpc});
    chk({tag, ".valid"}, {31'd0, ir_valid}, {31'd0, m_v});
    chk({tag, ".cnt"},   {16'd0, fetch_cnt}, m_cnt);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_all(tag);
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      if (v[15:12] == JMP) v[15:12] = 4'hA;
      rom[i] = v;
    end
    rom[100] = {JMP, 8'd40, 4'd0};

    // Power-on reset.
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    cmp_all("reset");
    rst = 1'b0;

    // BOOT bubble then sequential fetch of 0..3.
    step("boot");
    chk("boot_valid", {31'd0, ir_valid}, 32'd0);
    for (int i = 0; i < 4; i++) step("seq");
    chk("seq_irpc", {24'd0, ir_pc}, 32'd3);
    chk("seq_ir", {16'd0, ir}, {16'd0, rom[3]});
    chk("seq_cnt", {16'd0, fetch_cnt}, 32'd4);

    // Stall while ir holds op@5.
    redirect = 1'b1; redirect_pc = 8'd5;
    step("redir5");
    redirect = 1'b0;
    step("fetch5");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall_irpc", {24'd0, ir_pc}, 32'd5);
      chk("stall_pc", {24'd0, pc}, 32'd6);
    end
    stall = 1'b0;
    step("release");
    chk("release_irpc", {24'd0, ir_pc}, 32'd6);

    // Redirect overriding a stall at pc=10.
    redirect = 1'b1; redirect_pc = 8'd10;
    step("redir10");
    stall = 1'b1; redirect_pc = 8'd40;
    step("redir_stall");
    chk("rs_valid", {31'd0, ir_valid}, 32'd0);
    chk("rs_pc", {24'd0, pc}, 32'd40);
    stall = 1'b0; redirect = 1'b0;
    step("target40");
    chk("t40_irpc", {24'd0, ir_pc}, 32'd40);
    chk("t40_ir", {16'd0, ir}, {16'd0, rom[40]});

    // PC wrap.
    redirect = 1'b1; redirect_pc = 8'd254;
    step("redir254");
    redirect = 1'b0;
    step("f254");
    step("f255");
    chk("wrap_pc", {24'd0, pc}, 32'd0);
    chk("wrap_irpc255", {24'd0, ir_pc}, 32'd255);
    step("f0");
    chk("wrap_irpc0", {24'd0, ir_pc}, 32'd0);

    // JMP at address 100.
    redirect = 1'b1; redirect_pc = 8'd100;
    step("redir100");
    redirect = 1'b0;
    step("jmp");
`ifdef JMP_FOLD_EN
    chk("fold_valid", {31'd0, ir_valid}, 32'd0);
    chk("fold_pc", {24'd0, pc}, 32'd40);
    step("fold_target");
    chk("fold_ir", {16'd0, ir}, {16'd0, rom[40]});
`else
    chk("jmp_ir", {16'd0, ir}, {16'd0, rom[100]});
    chk("jmp_pc", {24'd0, pc}, 32'd101);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom % 4) == 0;
      redirect    = ($urandom % 10) == 0;
      redirect_pc = 8'($urandom);
      step("rand");
    end

    // Async reset in the middle of HOLD at pc=77.
    stall = 1'b0; redirect = 1'b1; redirect_pc = 8'd77;
    step("redir77");
    redirect = 1'b0; stall = 1'b1;
    step("hold77");
    chk("hold77_pc", {24'd0, pc}, 32'd77);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_pc", {24'd0, pc}, 32'd0);
    chk("arst_valid", {31'd0, ir_valid}, 32'd0);
    chk("arst_cnt", {16'd0, fetch_cnt}, 32'd0);
    chk("arst_ir", {16'd0, ir}, 32'd0);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    step("boot2");
    step("post_reset");
    chk("post_reset_ir", {16'd0, ir}, {16'd0, rom[0]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
